incr_unit: RTL and testbench

- Execute-stage operator module for Nock opcode 4 (increment).
- Selected by the traversal/execute controller when a stack node's head opcode is `increment`. The controller muxes memory ownership to this block for the duration of the operation.
- Reads the operand, adds one, and rewrites the stack node in place as a finished atom node.
- Returns a finished strobe plus the sys_func/state the controller resumes with.

---
 rtl/incr_unit_pkg.sv | 66 ++++++
 rtl/incr_unit_mem_req_port.sv | 94 +++++++++
 rtl/incr_unit.sv | 199 +++++++++++++++++++
 tb/tb_incr_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/incr_unit_pkg.sv
// Shared definitions for the Nock execute-stage operator units.
// Word layout: {tag[TAG_W-1:0], hed[NOUN_W-1:0], tel[NOUN_W-1:0]}.
// Tag bits: [7] execute pending, [3:2] visit bits, [1:0] {hed type, tel type} (1 = atom).
package incr_unit_pkg;

   // Default geometry of a memory word
   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned NOUN_W_DEF = 28;
   localparam int unsigned TAG_W_DEF  = 8;
   localparam int unsigned DATA_W_DEF = TAG_W_DEF + 2 * NOUN_W_DEF;

   // Field positions for the default geometry
   localparam int unsigned TAG_END      = DATA_W_DEF - 1;
   localparam int unsigned TAG_START    = 2 * NOUN_W_DEF;
   localparam int unsigned HED_END      = 2 * NOUN_W_DEF - 1;
   localparam int unsigned HED_START    = NOUN_W_DEF;
   localparam int unsigned TEL_END      = NOUN_W_DEF - 1;
   localparam int unsigned TEL_START    = 0;
   localparam int unsigned TAG_EXEC_BIT = 7;
   localparam int unsigned TAG_VISIT_HI = 3;
   localparam int unsigned TAG_VISIT_LO = 2;

   // tag[1:0] = {hed type, tel type}; a set bit marks an atom
   typedef enum logic [1:0] {
      CELL_CELL = 2'b00,
      CELL_ATOM = 2'b01,
      ATOM_CELL = 2'b10,
      ATOM_ATOM = 2'b11
   } tag_type_e;

   typedef enum logic [1:0] {
      MEM_NOP      = 2'd0,
      GET_CONTENTS = 2'd1,
      SET_CONTENTS = 2'd2
   } mem_func_e;

   // Resume codes handed back to the traversal/execute controller
   localparam logic [3:0] SYS_FUNC_TRAVERSE = 4'h2;
   localparam logic [3:0] SYS_FUNC_EXECUTE  = 4'h3;
   localparam logic [3:0] SYS_TRAVERSE_POP  = 4'h2;
   localparam logic [3:0] SYS_EXECUTE_ERROR = 4'hF;

   // Controller mux select for this operator (Nock opcode 4)
   localparam logic [3:0] MUX_INCR = 4'd4;

   localparam logic [7:0] INCR_ERR_NONE = 8'h00;
   localparam logic [7:0] INCR_ERR_CELL = 8'h01;
   localparam logic [7:0] INCR_ERR_OVF  = 8'h02;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StReadWait,
      StAdd,
      StWrite,
      StWriteWait,
      StDone,
      StFail
   } incr_state_e;

   typedef enum logic {
      PortIdle,
      PortWait
   } port_state_e;

endpackage

// File: rtl/incr_unit_mem_req_port.sv
// Single-request memory handshake: issue, hold, wait.
// A req_i pulse registers func/address/data and raises mem_execute_o for exactly one cycle;
// the request stays on the bus until mem_ready_i, which is reported on done_o.
// abort_i drops any pending request and clears the bus; a later mem_ready_i is ignored.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_i, abort_i    issue request / abandon request
//   func_i, addr_i, wdata_i   request contents
//   mem_ready_i       memory completion pulse
//   done_o            completion of the pending request (combinational)
//   mem_execute_o, mem_func_o, address_o, write_data_o   memory bus
module mem_req_port
   import incr_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              abort_i,
   input  logic [1:0]        func_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              mem_ready_i,
   output logic              done_o,
   output logic              mem_execute_o,
   output logic [1:0]        mem_func_o,
   output logic [ADDR_W-1:0] address_o,
   output logic [DATA_W-1:0] write_data_o
);

   port_state_e       state_q, state_d;
   logic              exec_q, exec_d;
   logic [1:0]        func_q, func_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      state_d = state_q;
      exec_d  = 1'b0;
      func_d  = func_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_o  = 1'b0;
      if (abort_i) begin
         state_d = PortIdle;
         func_d  = '0;
         addr_d  = '0;
         data_d  = '0;
      end else begin
         unique case (state_q)
            PortIdle: begin
               if (req_i) begin
                  state_d = PortWait;
                  exec_d  = 1'b1;
                  func_d  = func_i;
                  addr_d  = addr_i;
                  data_d  = wdata_i;
               end
            end
            PortWait: begin
               if (mem_ready_i) begin
                  done_o  = 1'b1;
                  state_d = PortIdle;
               end
            end
            default: state_d = PortIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PortIdle;
         exec_q  <= 1'b0;
         func_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         exec_q  <= exec_d;
         func_q  <= func_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign mem_execute_o = exec_q;
   assign mem_func_o    = func_q;
   assign address_o     = addr_q;
   assign write_data_o  = data_q;

endmodule

// File: rtl/incr_unit.sv
// Nock opcode 4 (increment) operator unit.
// Reads the operand (tel directly, or the hed of the atom node tel points at), adds one and
// rewrites the executing stack node in place as {ATOM_ATOM, result, 0}.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   start                        high while the controller mux selects this unit
//   module_address, module_data  node being executed
//   module_finished              done, held until start drops
//   execute_return_sys_func/state  resume point for the controller
//   error                        0 = ok, INCR_ERR_CELL / INCR_ERR_OVF
//   mem_execute, mem_func, address1, write_data, read_data1, mem_ready   memory port
module incr_unit
   import incr_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NOUN_W = NOUN_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] module_address,
   input  logic [DATA_W-1:0] module_data,
   output logic              module_finished,
   output logic [3:0]        execute_return_sys_func,
   output logic [3:0]        execute_return_state,
   output logic [7:0]        error,
   output logic              mem_execute,
   output logic [1:0]        mem_func,
   output logic [ADDR_W-1:0] address1,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data1,
   input  logic              mem_ready
);

   incr_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NOUN_W-1:0] tel_q, tel_d;
   logic              tel_atom_q, tel_atom_d;
   logic [NOUN_W-1:0] operand_q, operand_d;
   logic [NOUN_W-1:0] result_q, result_d;
   logic [7:0]        err_q, err_d;

   logic              req;
   mem_func_e         req_func;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              port_done;

   logic [TAG_W-1:0]  rd_tag;
   logic [NOUN_W-1:0] rd_hed;

   assign rd_tag = read_data1[DATA_W-1 -: TAG_W];
   assign rd_hed = read_data1[2*NOUN_W-1 -: NOUN_W];

   // Only the tel field and the tel-type bit of the node matter for an increment
   logic unused_fields;
   assign unused_fields = ^{module_data[DATA_W-1:2*NOUN_W+1], module_data[2*NOUN_W-1:NOUN_W],
                            read_data1[NOUN_W-1:0], rd_tag[TAG_EXEC_BIT-1:2]};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      tel_d      = tel_q;
      tel_atom_d = tel_atom_q;
      operand_d  = operand_q;
      result_d   = result_q;
      err_d      = err_q;
      req        = 1'b0;
      req_func   = MEM_NOP;
      req_addr   = '0;
      req_wdata  = '0;

      if (state_q != StIdle && !start) begin
         // Deselected: abandon whatever is in flight, nothing new is issued
         state_d = StIdle;
         err_d   = INCR_ERR_NONE;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  addr_d     = module_address;
                  tel_d      = module_data[NOUN_W-1:0];
                  tel_atom_d = module_data[2*NOUN_W];
                  state_d    = StCheck;
               end
            end
            StCheck: begin
               if (tel_atom_q) begin
                  operand_d = tel_q;
                  state_d   = StAdd;
               end else begin
                  req      = 1'b1;
                  req_func = GET_CONTENTS;
                  req_addr = tel_q[ADDR_W-1:0];
                  state_d  = StReadWait;
               end
            end
            StReadWait: begin
               if (port_done) begin
                  if (rd_tag[1:0] == ATOM_ATOM && !rd_tag[TAG_EXEC_BIT]) begin
                     operand_d = rd_hed;
                     state_d   = StAdd;
                  end else begin
                     err_d   = INCR_ERR_CELL;
                     state_d = StFail;
                  end
               end
            end
            StAdd: begin
               // No indirect atoms, so a saturated operand cannot be incremented
               if (&operand_q) begin
                  err_d   = INCR_ERR_OVF;
                  state_d = StFail;
               end else begin
                  result_d = operand_q + NOUN_W'(1);
                  state_d  = StWrite;
               end
            end
            StWrite: begin
               req       = 1'b1;
               req_func  = SET_CONTENTS;
               req_addr  = addr_q;
               req_wdata = {TAG_W'(ATOM_ATOM), result_q, NOUN_W'(0)};
               state_d   = StWriteWait;
            end
            StWriteWait: begin
               if (port_done) state_d = StDone;
            end
            StDone, StFail: begin
               // Held until start drops (handled above)
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         tel_q      <= '0;
         tel_atom_q <= 1'b0;
         operand_q  <= '0;
         result_q   <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tel_q      <= tel_d;
         tel_atom_q <= tel_atom_d;
         operand_q  <= operand_d;
         result_q   <= result_d;
         err_q      <= err_d;
      end
   end

   mem_req_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_req_port (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req),
      .abort_i       (!start),
      .func_i        (req_func),
      .addr_i        (req_addr),
      .wdata_i       (req_wdata),
      .mem_ready_i   (mem_ready),
      .done_o        (port_done),
      .mem_execute_o (mem_execute),
      .mem_func_o    (mem_func),
      .address_o     (address1),
      .write_data_o  (write_data)
   );

   always_comb begin
      module_finished         = 1'b0;
      execute_return_sys_func = 4'h0;
      execute_return_state    = 4'h0;
      unique case (state_q)
         StDone: begin
            module_finished         = 1'b1;
            execute_return_sys_func = SYS_FUNC_TRAVERSE;
            execute_return_state    = SYS_TRAVERSE_POP;
         end
         StFail: begin
            module_finished         = 1'b1;
            execute_return_sys_func = SYS_FUNC_EXECUTE;
            execute_return_state    = SYS_EXECUTE_ERROR;
         end
         default: ;
      endcase
   end

   assign error = err_q;

endmodule

// File: tb/tb_incr_unit.sv
// Randomised bench for incr_unit with a reference model and a reactive memory responder.
module tb_incr_unit;
   import incr_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  module_address;
   logic [63:0] module_data;
   logic        module_finished;
   logic [3:0]  execute_return_sys_func;
   logic [3:0]  execute_return_state;
   logic [7:0]  error;
   logic        mem_execute;
   logic [1:0]  mem_func;
   logic [9:0]  address1;
   logic [63:0] write_data;
   logic [63:0] read_data1;
   logic        mem_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mem [0:1023];
   int          lat = 1;
   bit          chk_hold = 1'b1;
   logic [1:0]  req_f [$];
   logic [9:0]  req_a [$];
   logic [63:0] req_d [$];

   incr_unit dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .module_address          (module_address),
      .module_data             (module_data),
      .module_finished         (module_finished),
      .execute_return_sys_func (execute_return_sys_func),
      .execute_return_state    (execute_return_state),
      .error                   (error),
      .mem_execute             (mem_execute),
      .mem_func                (mem_func),
      .address1                (address1),
      .write_data              (write_data),
      .read_data1              (read_data1),
      .mem_ready               (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory responder: one request at a time, answers after lat cycles
   initial begin
      logic [1:0]  f;
      logic [9:0]  a;
      logic [63:0] d;
      mem_ready  = 1'b0;
      read_data1 = '0;
      forever begin
         @(posedge clk); #2;
         if (mem_execute && rst) begin
            f = mem_func;
            a = address1;
            d = write_data;
            req_f.push_back(f);
            req_a.push_back(a);
            req_d.push_back(d);
            for (int i = 0; i < lat; i++) begin
               @(posedge clk); #2;
               if (chk_hold) begin
                  check_eq("hold_exec_pulse", {63'd0, mem_execute}, 64'd0);
                  check_eq("hold_func", {62'd0, mem_func}, {62'd0, f});
                  check_eq("hold_addr", {54'd0, address1}, {54'd0, a});
                  check_eq("hold_wdata", write_data, d);
               end
            end
            if (f == GET_CONTENTS) read_data1 = mem[a];
            mem_ready = 1'b1;
            @(posedge clk); #2;
            mem_ready  = 1'b0;
            read_data1 = '0;
         end
      end
   end

   // Reference: what an increment of this node must do, given the memory image
   task automatic run_op(input logic [9:0] addr, input logic [63:0] data, input int l,
                         input int extra);
      logic [27:0] tel, operand;
      logic [63:0] w;
      int          exp_reads, exp_nreq, cyc;
      logic [7:0]  exp_err;
      tel       = data[27:0];
      exp_reads = 0;
      exp_err   = 8'h00;
      operand   = '0;
      if (data[56]) begin
         operand = tel;
      end else begin
         exp_reads = 1;
         w = mem[tel[9:0]];
         if (w[57:56] == 2'b11 && !w[63]) operand = w[55:28];
         else exp_err = 8'h01;
      end
      if (exp_err == 8'h00 && operand == 28'hFFFFFFF) exp_err = 8'h02;
      exp_nreq = exp_reads + ((exp_err == 8'h00) ? 1 : 0);

      req_f.delete();
      req_a.delete();
      req_d.delete();
      lat            = l;
      chk_hold       = 1'b1;
      module_address = addr;
      module_data    = data;
      start          = 1'b1;
      cyc            = 0;
      while (!module_finished && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("finished", {63'd0, module_finished}, 64'd1);
      check_eq("error", {56'd0, error}, {56'd0, exp_err});
      check_eq("ret_func", {60'd0, execute_return_sys_func},
               (exp_err == 8'h00) ? 64'h2 : 64'h3);
      check_eq("ret_state", {60'd0, execute_return_state},
               (exp_err == 8'h00) ? 64'h2 : 64'hF);
      for (int i = 0; i < extra; i++) begin
         @(posedge clk); #1;
         check_eq("finished_held", {63'd0, module_finished}, 64'd1);
      end
      check_eq("req_count", req_f.size(), exp_nreq);
      if (req_f.size() == exp_nreq) begin
         if (exp_reads == 1) begin
            check_eq("read_func", {62'd0, req_f[0]}, {62'd0, GET_CONTENTS});
            check_eq("read_addr", {54'd0, req_a[0]}, {54'd0, tel[9:0]});
         end
         if (exp_err == 8'h00) begin
            check_eq("write_func", {62'd0, req_f[exp_nreq-1]}, {62'd0, SET_CONTENTS});
            check_eq("write_addr", {54'd0, req_a[exp_nreq-1]}, {54'd0, addr});
            check_eq("write_data", req_d[exp_nreq-1], {8'h03, operand + 28'd1, 28'd0});
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      check_eq("finished_clear", {63'd0, module_finished}, 64'd0);
      check_eq("error_clear", {56'd0, error}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_fin"}, {63'd0, module_finished}, 64'd0);
      check_eq({tag, "_ret"}, {56'd0, execute_return_sys_func, execute_return_state}, 64'd0);
      check_eq({tag, "_err"}, {56'd0, error}, 64'd0);
      check_eq({tag, "_bus"}, {51'd0, mem_execute, mem_func, address1}, 64'd0);
      check_eq({tag, "_wdata"}, write_data, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] d;
      logic [7:0]  tg;
      logic [27:0] tel;
      int          cyc, kind;
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
      rst            = 1'b0;
      start          = 1'b0;
      module_address = '0;
      module_data    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_op(10'd10, {8'h81, 28'd4, 28'd41}, 2, 0);
      mem[20] = {8'h03, 28'd99, 28'd0};
      run_op(10'd10, {8'h80, 28'd4, 28'd20}, 3, 0);
      mem[20] = {8'h00, 28'd5, 28'd6};
      run_op(10'd10, {8'h80, 28'd4, 28'd20}, 1, 0);
      mem[20] = {8'h83, 28'd5, 28'd0};
      run_op(10'd11, {8'h80, 28'd4, 28'd20}, 1, 0);
      run_op(10'd12, {8'h81, 28'd4, 28'hFFFFFFF}, 1, 0);
      mem[30] = {8'h03, 28'hFFFFFFF, 28'd0};
      run_op(10'd13, {8'h80, 28'd0, 28'd30}, 1, 0);
      mem[31] = {8'h03, 28'hFFFFFFE, 28'd0};
      run_op(10'd14, {8'h80, 28'd0, 28'd31}, 7, 5);

      // Abort: start dropped while the read is outstanding
      mem[40] = {8'h03, 28'd7, 28'd0};
      req_f.delete(); req_a.delete(); req_d.delete();
      lat = 6; chk_hold = 1'b0;
      module_address = 10'd15; module_data = {8'h80, 28'd0, 28'd40}; start = 1'b1;
      cyc = 0;
      while (req_f.size() == 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check_eq("abort_read_issued", req_f.size(), 1);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check_all_zero("abort_read");
      repeat (12) @(posedge clk);
      #1;
      check_eq("abort_no_new_req", req_f.size(), 1);
      check_all_zero("abort_after");

      // Async reset while the write is outstanding
      req_f.delete(); req_a.delete(); req_d.delete();
      lat = 6; chk_hold = 1'b0;
      module_address = 10'd16; module_data = {8'h81, 28'd0, 28'd50}; start = 1'b1;
      cyc = 0;
      while (req_f.size() == 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check_eq("rst_write_issued", req_f.size(), 1);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("post_rst");
      run_op(10'd17, {8'h81, 28'd0, 28'd123}, 2, 0);

      // Randomised operations
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         tg   = 8'($urandom);
         if (kind == 0) begin
            tel = ($urandom_range(0, 7) == 0) ? 28'hFFFFFFF : 28'($urandom);
            d = {tg[7:1], 1'b1, 28'($urandom), tel};
         end else begin
            tel = 28'($urandom_range(0, 1023));
            case ($urandom_range(0, 4))
               0, 1: mem[tel[9:0]] = {8'h03, 28'($urandom), 28'($urandom)};
               2:    mem[tel[9:0]] = {8'h03, 28'hFFFFFFF, 28'd0};
               3:    mem[tel[9:0]] = {8'h83, 28'($urandom), 28'd0};
               default: mem[tel[9:0]] = {$urandom, $urandom};
            endcase
            d = {tg[7:1], 1'b0, 28'($urandom), tel};
         end
         run_op(10'($urandom), d, $urandom_range(1, 7), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
